// File: rtl/div3_pkg.sv
// Shared types for the divide-by-3 serializer: FSM states and the mod-3 remainder.
package div3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [1:0] rem_t;

  localparam rem_t REM_ZERO = 2'd0;

endpackage

// File: rtl/div3_rem_step.sv
// One step of MSB-first long division by 3: folds one bit into the running remainder.
module div3_rem_step
  import div3_pkg::*;
(
  input  logic [1:0] rem,
  input  logic       din,
  output logic [1:0] rem_next,
  output logic       q_bit
);

  // t = 2*rem + din ranges 0..5; encode t mod 3 and (t >= 3) directly.
  always_comb begin
    rem_next = REM_ZERO;
    q_bit    = 1'b0;
    case ({rem, din})
      3'b000: begin rem_next = 2'd0; q_bit = 1'b0; end
      3'b001: begin rem_next = 2'd1; q_bit = 1'b0; end
      3'b010: begin rem_next = 2'd2; q_bit = 1'b0; end
      3'b011: begin rem_next = 2'd0; q_bit = 1'b1; end
      3'b100: begin rem_next = 2'd1; q_bit = 1'b1; end
      3'b101: begin rem_next = 2'd2; q_bit = 1'b1; end
      default: begin rem_next = REM_ZERO; q_bit = 1'b0; end
    endcase
  end

endmodule

// File: rtl/div3_serializer.sv
// Parallel-to-serial shifter (MSB first) that computes the quotient and remainder
// of the frame divided by 3 on the fly, one bit per clock.
module div3_serializer
  import div3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             q_bit,
  output logic [1:0]       rem,
  output logic             done,
  output logic             div3
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] cnt_reg;
  rem_t             rem_reg;
  rem_t             step_rem;
  logic             step_q;
  logic             cnt_zero;

  assign cnt_zero = (cnt_reg == '0);

  div3_rem_step u_step (
    .rem      (rem_reg),
    .din      (shift_reg[WIDTH-1]),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      rem_reg   <= REM_ZERO;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= in_data;
            cnt_reg   <= CNT_LOAD;
            rem_reg   <= REM_ZERO;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          rem_reg   <= step_rem;
          if (!cnt_zero) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          shift_reg <= shift_reg;
        end
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (cnt_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready is gated by reset so it reads 0 for the whole reset window.
  always_comb begin
    in_ready   = 1'b0;
    dout       = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    q_bit      = 1'b0;
    done       = 1'b0;
    div3       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = ~reset;
      end
      SHIFT: begin
        dout       = shift_reg[WIDTH-1];
        dout_valid = 1'b1;
        dout_last  = cnt_zero;
        q_bit      = step_q;
      end
      DONE: begin
        done = 1'b1;
        div3 = (rem_reg == REM_ZERO);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign rem = rem_reg;

endmodule

// File: tb/tb_div3_serializer.sv
// Randomized self-checking bench for div3_serializer against an arithmetic reference.
module tb_div3_serializer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         dout;
  logic         dout_valid;
  logic         dout_last;
  logic         q_bit;
  logic [1:0]   rem;
  logic         done;
  logic         div3;

  int checks   = 0;
  int failures = 0;

  div3_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .q_bit      (q_bit),
    .rem        (rem),
    .done       (done),
    .div3       (div3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".outs"}, {26'd0, dout, dout_valid, dout_last, q_bit, done, div3}, 32'd0);
    chk({tag, ".rem"}, 32'(rem), 32'd0);
  endtask

  // Caller sits just after a negedge with the DUT idle. hold=1 keeps in_valid high
  // carrying next_data through the frame, which must be ignored until idle again.
  task automatic send_frame(input logic [W-1:0] v, input bit hold, input logic [W-1:0] next_data);
    int unsigned val;
    int unsigned q_exp;
    logic [W-1:0] q_seen;
    val   = int'(v);
    q_exp = val / 3;
    q_seen = '0;
    chk("idle.in_ready", 32'(in_ready), 32'd1);
    chk("idle.done", 32'(done), 32'd0);
    chk("idle.dout_valid", 32'(dout_valid), 32'd0);
    chk("idle.div3", 32'(div3), 32'd0);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    for (int k = 0; k < W; k++) begin
      if (hold) begin
        in_valid = 1'b1;
        in_data  = next_data;
      end else begin
        in_valid = 1'($urandom);
        in_data  = W'($urandom);
      end
      chk("shift.in_ready", 32'(in_ready), 32'd0);
      chk("shift.dout_valid", 32'(dout_valid), 32'd1);
      chk("shift.dout", 32'(dout), 32'((val >> (W - 1 - k)) & 1));
      chk("shift.last", 32'(dout_last), 32'(k == W - 1));
      chk("shift.rem", 32'(rem), 32'((val >> (W - k)) % 3));
      chk("shift.done", 32'(done), 32'd0);
      q_seen[W-1-k] = q_bit;
      @(negedge clk);
    end
    in_valid = hold;
    in_data  = hold ? next_data : '0;
    chk("done.done", 32'(done), 32'd1);
    chk("done.dout_valid", 32'(dout_valid), 32'd0);
    chk("done.dout", {30'd0, dout, q_bit}, 32'd0);
    chk("done.rem", 32'(rem), 32'(val % 3));
    chk("done.div3", 32'(div3), 32'(val % 3 == 0));
    chk("done.in_ready", 32'(in_ready), 32'd0);
    chk("frame.quotient", 32'(q_seen), q_exp);
    $display("frame data=0x%02h q=0x%02h rem=%0d div3=%0b", v, q_seen, rem, div3);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] dir_vec [4];
    dir_vec[0] = 8'h15;
    dir_vec[1] = 8'h64;
    dir_vec[2] = 8'hFF;
    dir_vec[3] = 8'h00;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    chk_all_zero("reset0");
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset1");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send_frame(dir_vec[i], 1'b0, '0);
    end

    // Back-to-back with in_valid held high: second word accepted only once idle.
    send_frame(8'h03, 1'b1, 8'h05);
    send_frame(8'h05, 1'b0, '0);

    // Reset between edges after three bits of 0xAA.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b0;
      chk("abort.dout", 32'(dout), 32'((8'hAA >> (7 - k)) & 1));
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    chk_all_zero("abort.async");
    in_valid = 1'b1;
    @(negedge clk);
    chk_all_zero("abort.held");
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort.in_ready", 32'(in_ready), 32'd1);
      chk("abort.no_done", {30'd0, done, dout_valid}, 32'd0);
    end
    send_frame(8'h09, 1'b0, '0);

    for (int i = 0; i < 24; i++) begin
      send_frame(W'($urandom), 1'b0, '0);
    end

    chk("final.in_ready", 32'(in_ready), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
